// File: rtl/sram_stream_reader.sv
// sram_stream_reader
//
// Read initiator for the generic single-port SRAM interface. A start command
// reads len_i contiguous words beginning at start_addr_i. The address wraps
// modulo NumWords. The words are presented in address order on a valid/ready
// stream. Requests are credit-limited, so every response returning after the
// fixed Latency always has a free buffer slot, even under full backpressure.
//
// Ports
//   clk_i, rst_i      clock; synchronous active-high reset
//   start_i           start command, accepted only while busy_o=0
//   start_addr_i      first word address
//   len_i             words to read, 0..NumWords (0 just pulses done_o)
//   busy_o            transfer in progress
//   done_o            one-cycle pulse after the last stream handshake
//   req_o/we_o/addr_o/wdata_o/be_o   SRAM request side (read-only: we/wdata/be are 0)
//   rdata_i           SRAM read data, valid Latency cycles after req_o
//   data_o/valid_o/ready_i           output stream

module sram_stream_reader #(
  parameter int NumWords  = 1024,
  parameter int DataWidth = 128,
  parameter int ByteWidth = 8,
  parameter int Latency   = 1,
  parameter int BufDepth  = 4,
  parameter int AddrWidth = (NumWords > 1) ? $clog2(NumWords) : 1,
  parameter int BeWidth   = (DataWidth + ByteWidth - 1) / ByteWidth
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic [AddrWidth-1:0] start_addr_i,
  input  logic [AddrWidth:0]   len_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 req_o,
  output logic                 we_o,
  output logic [AddrWidth-1:0] addr_o,
  output logic [DataWidth-1:0] wdata_o,
  output logic [BeWidth-1:0]   be_o,
  input  logic [DataWidth-1:0] rdata_i,
  output logic [DataWidth-1:0] data_o,
  output logic                 valid_o,
  input  logic                 ready_i
);

  localparam int CntWidth    = AddrWidth + 1;
  localparam int PtrWidth    = (BufDepth > 1) ? $clog2(BufDepth) : 1;
  localparam int BufCntWidth = $clog2(BufDepth + 1);
  localparam int FlightWidth = (Latency > 0) ? $clog2(Latency + 1) : 1;
  localparam int LatRegWidth = (Latency > 0) ? Latency : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_e;

  state_e state_q, state_d;

  logic [AddrWidth-1:0]   addr_q;
  logic [CntWidth-1:0]    issue_cnt_q;
  logic [CntWidth-1:0]    out_cnt_q;
  logic                   done_q;
  logic [LatRegWidth-1:0] lat_sr_q;
  logic [FlightWidth-1:0] in_flight_q;
  logic [DataWidth-1:0]   buf_mem [BufDepth];
  logic [PtrWidth-1:0]    wr_ptr_q, rd_ptr_q;
  logic [BufCntWidth-1:0] buf_count_q;

  logic start_ok;
  logic req;
  logic push;
  logic pop;

  function automatic logic [PtrWidth-1:0] ptr_inc(input logic [PtrWidth-1:0] p);
    return (p == PtrWidth'(BufDepth - 1)) ? '0 : p + PtrWidth'(1);
  endfunction

  assign start_ok = (state_q == IDLE) && start_i && (len_i != '0);
  assign pop      = (buf_count_q != '0) && ready_i;

  // ---------------------------------------------------------------- FSM
  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // A credit is one slot that is neither holding a word nor reserved by an
  // outstanding read. Only registered occupancy counts, so a pop in this
  // cycle frees its slot for issue only from the next cycle.
  // NOTE: every output of this block gets a default first; a path that
  // leaves one unassigned would infer a latch.
  always_comb begin
    state_d = state_q;
    req     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_ok) state_d = RUN;
      end
      RUN: begin
        req = (int'(in_flight_q) + int'(buf_count_q)) < BufDepth;
        if (req && issue_cnt_q == CntWidth'(1)) state_d = DRAIN;
      end
      DRAIN: begin
        if (pop && out_cnt_q == CntWidth'(1)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // ------------------------------------------------ address and counters
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      addr_q      <= '0;
      issue_cnt_q <= '0;
      out_cnt_q   <= '0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (state_q == IDLE && start_i) begin
        if (len_i == '0) begin
          done_q <= 1'b1;
        end else begin
          addr_q      <= start_addr_i;
          issue_cnt_q <= len_i;
          out_cnt_q   <= len_i;
        end
      end
      if (req) begin
        addr_q      <= (addr_q == AddrWidth'(NumWords - 1)) ? '0 : addr_q + AddrWidth'(1);
        issue_cnt_q <= issue_cnt_q - CntWidth'(1);
      end
      if (pop) out_cnt_q <= out_cnt_q - CntWidth'(1);
      if (state_q == DRAIN && state_d == IDLE) done_q <= 1'b1;
    end
  end

  // ---------------------------------------------------- response tracking
  // Bit i of lat_sr_q marks a read issued i+1 cycles ago; the tail bit lines
  // up with rdata_i. in_flight_q mirrors its population count.
  if (Latency == 0) begin : g_lat0
    assign push        = req;
    assign lat_sr_q    = '0;
    assign in_flight_q = '0;
  end else begin : g_lat
    assign push = lat_sr_q[Latency-1];

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        lat_sr_q    <= '0;
        in_flight_q <= '0;
      end else begin
        lat_sr_q <= (lat_sr_q << 1) | LatRegWidth'(req);
        case ({req, push})
          2'b10:   in_flight_q <= in_flight_q + FlightWidth'(1);
          2'b01:   in_flight_q <= in_flight_q - FlightWidth'(1);
          default: in_flight_q <= in_flight_q;
        endcase
      end
    end
  end

  // ------------------------------------------------------ response buffer
  // NOTE: the storage array has no reset; occupancy is governed entirely by
  // the reset pointers and count, so stale contents are never visible.
  always_ff @(posedge clk_i) begin
    if (push) buf_mem[wr_ptr_q] <= rdata_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      buf_count_q <= '0;
    end else begin
      if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      case ({push, pop})
        2'b10:   buf_count_q <= buf_count_q + BufCntWidth'(1);
        2'b01:   buf_count_q <= buf_count_q - BufCntWidth'(1);
        default: buf_count_q <= buf_count_q;
      endcase
    end
  end

  // -------------------------------------------------------------- outputs
  assign busy_o  = (state_q != IDLE);
  assign done_o  = done_q;
  assign req_o   = req;
  assign we_o    = 1'b0;
  assign addr_o  = addr_q;
  assign wdata_o = '0;
  assign be_o    = '0;
  assign valid_o = (buf_count_q != '0);
  assign data_o  = buf_mem[rd_ptr_q];

  // ----------------------------------------------------------- assertions
  a_buf_depth: assert property (@(posedge clk_i) BufDepth >= 1)
    else $error("BufDepth must be at least 1");

  a_start_addr: assert property (@(posedge clk_i) disable iff (rst_i)
    start_ok |-> ({1'b0, start_addr_i} < CntWidth'(NumWords)))
    else $error("start_addr_i out of range");

  a_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i)
    push |-> (buf_count_q != BufCntWidth'(BufDepth)))
    else $error("response buffer overflow");

  a_no_write: assert property (@(posedge clk_i) we_o == 1'b0)
    else $error("we_o asserted");

endmodule

// File: tb/tb_sram_stream_reader.sv
module tb_sram_stream_reader;

  localparam int NW  = 1024;
  localparam int DW  = 32;
  localparam int AW  = 10;
  localparam int BEW = 4;
  // Three configurations: [0] Latency 1 / BufDepth 4, [1] 2 / 3, [2] 0 / 1.
  localparam int LAT [3] = '{1, 2, 0};
  localparam int BD  [3] = '{4, 3, 1};

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          start_s [3];
  logic [AW-1:0] saddr_s [3];
  logic [AW:0]   len_s   [3];
  logic          ready_s [3];
  logic          busy_s  [3];
  logic          done_s  [3];
  logic          req_s   [3];
  logic          we_s    [3];
  logic [AW-1:0] addr_s  [3];
  logic [DW-1:0] wdata_s [3];
  logic [BEW-1:0] be_s   [3];
  logic [DW-1:0] rdata_s [3];
  logic [DW-1:0] data_s  [3];
  logic          valid_s [3];

  // Contents of SRAM word a: address in the low half, a marked copy above.
  function automatic logic [DW-1:0] word_at(input logic [AW-1:0] a);
    return {16'hA5A5 ^ {6'd0, a}, 6'd0, a};
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_dut
    sram_stream_reader #(
      .NumWords (NW),
      .DataWidth(DW),
      .ByteWidth(8),
      .Latency  (LAT[g]),
      .BufDepth (BD[g])
    ) u_dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .start_i     (start_s[g]),
      .start_addr_i(saddr_s[g]),
      .len_i       (len_s[g]),
      .busy_o      (busy_s[g]),
      .done_o      (done_s[g]),
      .req_o       (req_s[g]),
      .we_o        (we_s[g]),
      .addr_o      (addr_s[g]),
      .wdata_o     (wdata_s[g]),
      .be_o        (be_s[g]),
      .rdata_i     (rdata_s[g]),
      .data_o      (data_s[g]),
      .valid_o     (valid_s[g]),
      .ready_i     (ready_s[g])
    );

    // Fixed-latency SRAM model.
    if (LAT[g] == 0) begin : g_comb
      assign rdata_s[g] = word_at(addr_s[g]);
    end else begin : g_pipe
      logic [DW-1:0] pipe [LAT[g]];
      always @(posedge clk) begin
        pipe[0] <= word_at(addr_s[g]);
        for (int i = 1; i < LAT[g]; i++) pipe[i] <= pipe[i-1];
      end
      assign rdata_s[g] = pipe[LAT[g]-1];
    end
  end

  // ------------------------------------------------------------ monitor
  int            cur = 0;
  int            cyc = 0;
  logic [DW-1:0] exp_q [$];
  logic [DW-1:0] obs_q [$];
  int            obs_cyc [$];
  logic [AW-1:0] addr_log [$];
  int            req_cyc [$];
  int            done_cnt = 0;
  int            done_cyc = 0;
  int            stab_err = 0;
  int            full_req_err = 0;
  logic          pv = 1'b0;
  logic          pr = 1'b0;
  logic [DW-1:0] pd = '0;

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (!rst) begin
      if (valid_s[cur] && ready_s[cur]) begin
        obs_q.push_back(data_s[cur]);
        obs_cyc.push_back(cyc);
      end
      if (req_s[cur]) begin
        addr_log.push_back(addr_s[cur]);
        req_cyc.push_back(cyc);
      end
      if (done_s[cur]) begin
        done_cnt = done_cnt + 1;
        done_cyc = cyc;
      end
      if (pv && !pr && (!valid_s[cur] || data_s[cur] !== pd)) stab_err = stab_err + 1;
      if (cur == 2 && valid_s[2] && req_s[2]) full_req_err = full_req_err + 1;
    end
    pv = valid_s[cur] && !rst;
    pr = ready_s[cur];
    pd = data_s[cur];
  end

  int n_checks = 0;
  int n_pass   = 0;

  // --------------------------------------------------- stimulus helpers
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_logs();
    exp_q.delete();
    obs_q.delete();
    obs_cyc.delete();
    addr_log.delete();
    req_cyc.delete();
  endtask

  task automatic start_xfer(input logic [AW-1:0] a, input int len, input bit accepted);
    start_s[cur] = 1'b1;
    saddr_s[cur] = a;
    len_s[cur]   = (AW+1)'(len);
    if (accepted)
      for (int i = 0; i < len; i++) exp_q.push_back(word_at(AW'(int'(a) + i)));
    tick(1);
    start_s[cur] = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit timed_out);
    int base;
    base = done_cnt;
    timed_out = 1'b1;
    for (int i = 0; i < budget; i++) begin
      tick(1);
      if (done_cnt != base) begin
        timed_out = 1'b0;
        break;
      end
    end
  endtask

  // ------------------------------------------------------------- tests
  task automatic test_reset();
    rst = 1'b1;
    tick(2);
    for (int g = 0; g < 3; g++) begin
      n_checks++;
      if ({busy_s[g], done_s[g], req_s[g], valid_s[g], we_s[g]} !== 5'b0 || addr_s[g] !== '0)
        $display("FAIL reset_state[%0d]: busy/done/req/valid/we=%b%b%b%b%b addr=%0d, need all 0",
                 g, busy_s[g], done_s[g], req_s[g], valid_s[g], we_s[g], addr_s[g]);
      else n_pass++;
    end
    rst = 1'b0;
    tick(2);
    n_checks++;
    if (busy_s[0] !== 1'b0 || valid_s[0] !== 1'b0)
      $display("FAIL idle_after_reset: busy=%b valid=%b, need 0 0", busy_s[0], valid_s[0]);
    else n_pass++;
  endtask

  task automatic test_basic();
    bit to;
    int dbase;
    logic [DW-1:0] e, o;
    cur = 0;
    clear_logs();
    ready_s[0] = 1'b1;
    dbase = done_cnt;
    start_xfer(AW'(16), 8, 1'b1);
    wait_done(100, to);
    n_checks++;
    if (to !== 1'b0) $display("FAIL basic_timeout: done_o not seen within 100 cycles");
    else n_pass++;
    for (int i = 0; i < 8; i++) begin
      n_checks++;
      if (i >= addr_log.size() || addr_log[i] !== AW'(16 + i))
        $display("FAIL basic_addr[%0d]: got %0d expected %0d", i, addr_log[i], 16 + i);
      else n_pass++;
    end
    n_checks++;
    if (req_cyc.size() != 8 || req_cyc[7] - req_cyc[0] != 7)
      $display("FAIL basic_req_back_to_back: %0d requests, span %0d, need 8 and 7",
               req_cyc.size(), req_cyc[req_cyc.size()-1] - req_cyc[0]);
    else n_pass++;
    n_checks++;
    if (obs_cyc.size() != 8 || obs_cyc[7] - obs_cyc[0] != 7)
      $display("FAIL basic_stream_back_to_back: %0d words, need 8 on consecutive cycles", obs_cyc.size());
    else n_pass++;
    n_checks++;
    if (obs_cyc.size() == 0 || done_cyc != obs_cyc[obs_cyc.size()-1] + 1)
      $display("FAIL basic_done_timing: done at cycle %0d, need one after last handshake", done_cyc);
    else n_pass++;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (obs_q.size() == 0) $display("FAIL basic_data: missing word, expected %h", e);
      else begin
        o = obs_q.pop_front();
        if (o !== e) $display("FAIL basic_data: got %h expected %h", o, e);
        else n_pass++;
      end
    end
    tick(3);
    n_checks++;
    if (done_cnt - dbase != 1) $display("FAIL basic_done_count: got %0d pulses expected 1", done_cnt - dbase);
    else n_pass++;
  endtask

  task automatic test_wrap();
    bit to;
    logic [AW-1:0] exp_a [4];
    logic [DW-1:0] e, o;
    exp_a = '{AW'(1022), AW'(1023), AW'(0), AW'(1)};
    cur = 0;
    clear_logs();
    start_xfer(AW'(1022), 4, 1'b1);
    wait_done(100, to);
    n_checks++;
    if (to !== 1'b0) $display("FAIL wrap_timeout: done_o not seen");
    else n_pass++;
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (i >= addr_log.size() || addr_log[i] !== exp_a[i])
        $display("FAIL wrap_addr[%0d]: got %0d expected %0d", i, addr_log[i], exp_a[i]);
      else n_pass++;
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (obs_q.size() == 0) $display("FAIL wrap_data: missing word, expected %h", e);
      else begin
        o = obs_q.pop_front();
        if (o !== e) $display("FAIL wrap_data: got %h expected %h", o, e);
        else n_pass++;
      end
    end
  endtask

  task automatic test_backpressure();
    bit to;
    int sbase;
    logic [DW-1:0] e, o;
    cur = 1;
    clear_logs();
    sbase = stab_err;
    ready_s[1] = 1'b0;
    start_xfer(AW'(40), 10, 1'b1);
    tick(20);
    n_checks++;
    if (addr_log.size() != 3) $display("FAIL bp_credit_limit: %0d requests issued, expected 3", addr_log.size());
    else n_pass++;
    n_checks++;
    if (valid_s[1] !== 1'b1 || data_s[1] !== word_at(AW'(40)))
      $display("FAIL bp_head: valid=%b data=%h, expected 1 %h", valid_s[1], data_s[1], word_at(AW'(40)));
    else n_pass++;
    n_checks++;
    if (stab_err != sbase || obs_q.size() != 0)
      $display("FAIL bp_hold: %0d stability errors, %0d words leaked, expected 0 0", stab_err - sbase, obs_q.size());
    else n_pass++;
    ready_s[1] = 1'b1;
    wait_done(200, to);
    n_checks++;
    if (to !== 1'b0 || addr_log.size() != 10)
      $display("FAIL bp_release: timeout=%b requests=%0d, expected 0 10", to, addr_log.size());
    else n_pass++;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (obs_q.size() == 0) $display("FAIL bp_data: missing word, expected %h", e);
      else begin
        o = obs_q.pop_front();
        if (o !== e) $display("FAIL bp_data: got %h expected %h", o, e);
        else n_pass++;
      end
    end
    n_checks++;
    if (obs_q.size() != 0) $display("FAIL bp_extra: %0d extra words, expected 0", obs_q.size());
    else n_pass++;
  endtask

  task automatic test_zero_and_ignored();
    bit to;
    logic [DW-1:0] e, o;
    cur = 0;
    clear_logs();
    ready_s[0] = 1'b1;
    start_xfer(AW'(5), 0, 1'b0);
    n_checks++;
    if (done_s[0] !== 1'b1 || busy_s[0] !== 1'b0)
      $display("FAIL zero_len_done: done=%b busy=%b, expected 1 0", done_s[0], busy_s[0]);
    else n_pass++;
    tick(1);
    n_checks++;
    if (done_s[0] !== 1'b0 || addr_log.size() != 0)
      $display("FAIL zero_len_quiet: done=%b requests=%0d, expected 0 0", done_s[0], addr_log.size());
    else n_pass++;
    clear_logs();
    start_xfer(AW'(100), 5, 1'b1);
    tick(2);
    n_checks++;
    if (busy_s[0] !== 1'b1) $display("FAIL ignored_busy: busy=%b expected 1", busy_s[0]);
    else n_pass++;
    start_xfer(AW'(500), 7, 1'b0);
    wait_done(100, to);
    tick(5);
    n_checks++;
    if (to !== 1'b0 || addr_log.size() != 5 || busy_s[0] !== 1'b0)
      $display("FAIL ignored_start: timeout=%b requests=%0d busy=%b, expected 0 5 0",
               to, addr_log.size(), busy_s[0]);
    else n_pass++;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (obs_q.size() == 0) $display("FAIL ignored_data: missing word, expected %h", e);
      else begin
        o = obs_q.pop_front();
        if (o !== e) $display("FAIL ignored_data: got %h expected %h", o, e);
        else n_pass++;
      end
    end
    n_checks++;
    if (obs_q.size() != 0) $display("FAIL ignored_extra: %0d extra words, expected 0", obs_q.size());
    else n_pass++;
  endtask

  task automatic test_latency0();
    bit to;
    int dbase, fbase;
    logic [DW-1:0] e, o;
    cur = 2;
    clear_logs();
    dbase = done_cnt;
    fbase = full_req_err;
    ready_s[2] = 1'b1;
    start_xfer(AW'(200), 6, 1'b1);
    to = 1'b1;
    for (int i = 0; i < 100; i++) begin
      ready_s[2] = ~ready_s[2];
      tick(1);
      if (done_cnt != dbase) begin
        to = 1'b0;
        break;
      end
    end
    ready_s[2] = 1'b1;
    n_checks++;
    if (to !== 1'b0) $display("FAIL lat0_timeout: done_o not seen");
    else n_pass++;
    n_checks++;
    if (full_req_err != fbase)
      $display("FAIL lat0_credit: req_o seen %0d times with buffer full, expected 0", full_req_err - fbase);
    else n_pass++;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (obs_q.size() == 0) $display("FAIL lat0_data: missing word, expected %h", e);
      else begin
        o = obs_q.pop_front();
        if (o !== e) $display("FAIL lat0_data: got %h expected %h", o, e);
        else n_pass++;
      end
    end
  endtask

  task automatic test_reset_mid();
    bit to;
    int dbase;
    logic [DW-1:0] e, o;
    cur = 0;
    clear_logs();
    ready_s[0] = 1'b1;
    start_xfer(AW'(300), 8, 1'b1);
    for (int i = 0; i < 50 && obs_q.size() < 3; i++) tick(1);
    n_checks++;
    if (obs_q.size() != 3) $display("FAIL rstmid_progress: %0d words before reset, expected 3", obs_q.size());
    else n_pass++;
    for (int i = 0; i < 3; i++) begin
      e = exp_q.pop_front();
      n_checks++;
      if (obs_q.size() == 0) $display("FAIL rstmid_data: missing word, expected %h", e);
      else begin
        o = obs_q.pop_front();
        if (o !== e) $display("FAIL rstmid_data: got %h expected %h", o, e);
        else n_pass++;
      end
    end
    dbase = done_cnt;
    rst = 1'b1;
    tick(1);
    n_checks++;
    if ({valid_s[0], busy_s[0], req_s[0], done_s[0]} !== 4'b0)
      $display("FAIL rstmid_abort: valid/busy/req/done=%b%b%b%b, expected 0000",
               valid_s[0], busy_s[0], req_s[0], done_s[0]);
    else n_pass++;
    rst = 1'b0;
    tick(4);
    n_checks++;
    if (done_cnt != dbase || valid_s[0] !== 1'b0)
      $display("FAIL rstmid_no_done: %0d done pulses, valid=%b, expected 0 0", done_cnt - dbase, valid_s[0]);
    else n_pass++;
    clear_logs();
    start_xfer(AW'(50), 2, 1'b1);
    wait_done(100, to);
    n_checks++;
    if (to !== 1'b0) $display("FAIL rstmid_restart_timeout: done_o not seen");
    else n_pass++;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (obs_q.size() == 0) $display("FAIL rstmid_restart_data: missing word, expected %h", e);
      else begin
        o = obs_q.pop_front();
        if (o !== e) $display("FAIL rstmid_restart_data: got %h expected %h", o, e);
        else n_pass++;
      end
    end
    n_checks++;
    if (obs_q.size() != 0) $display("FAIL rstmid_restart_extra: %0d extra words, expected 0", obs_q.size());
    else n_pass++;
  endtask

  initial begin
    for (int g = 0; g < 3; g++) begin
      start_s[g] = 1'b0;
      saddr_s[g] = '0;
      len_s[g]   = '0;
      ready_s[g] = 1'b1;
    end
    test_reset();
    test_basic();
    test_wrap();
    test_backpressure();
    test_zero_and_ignored();
    test_latency0();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached (%0d/%0d passed so far)", n_pass, n_checks);
    $fatal(1);
  end

endmodule
